// File: rtl/mnisc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mnisc_pkg
// Shared types and helpers for the MNISC-Q activation code datapath:
// dequantizer state encoding, code-width selector and the 2-bit level table.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
package mnisc_pkg;

  // Dequantizer control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Supported code widths, encoded as log2(N) - 1
  typedef enum logic [1:0] {
    CW_2  = 2'd0,
    CW_4  = 2'd1,
    CW_8  = 2'd2,
    CW_16 = 2'd3
  } cw_t;

  localparam logic [7:0] c_CODE_BITS_2  = 8'd2;
  localparam logic [7:0] c_CODE_BITS_4  = 8'd4;
  localparam logic [7:0] c_CODE_BITS_8  = 8'd8;
  localparam logic [7:0] c_CODE_BITS_16 = 8'd16;

  // Map the raw configured width onto a selector; unknown widths fall back to 2
  function automatic cw_t cw_decode(input logic [7:0] bits);
    cw_t cw;
    case (bits)
      c_CODE_BITS_4:  cw = CW_4;
      c_CODE_BITS_8:  cw = CW_8;
      c_CODE_BITS_16: cw = CW_16;
      default:        cw = CW_2;
    endcase
    return cw;
  endfunction

  // 2-bit symmetric level table (same table the quantizer encodes against)
  function automatic logic signed [2:0] dec2(input logic [1:0] code);
    logic signed [2:0] v;
    case (code)
      2'b00:   v = -3'sd3;
      2'b01:   v = -3'sd1;
      2'b10:   v = 3'sd1;
      default: v = 3'sd3;
    endcase
    return v;
  endfunction

  // Index of the last output sub-beat held in one input buffer (32/N - 1)
  function automatic logic [3:0] sub_last(input cw_t cw);
    logic [3:0] s;
    case (cw)
      CW_2:    s = 4'd15;
      CW_4:    s = 4'd7;
      CW_8:    s = 4'd3;
      default: s = 4'd1;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/act_dequant_unit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// act_dequant_unit_if
// Valid/ready stream bundle used for both the packed-code input and the
// int32-lane output of the activation dequantizer.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
interface act_dequant_unit_if #(
  parameter int BUS_W = 128
);
  logic [BUS_W-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface
`default_nettype wire

// File: rtl/mnisc_code_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mnisc_code_decoder
// Expands one MNISC-Q code (right-aligned in a 16-bit field) into a signed
// ACC_W-bit integer according to the selected code width.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module mnisc_code_decoder
  import mnisc_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  wire logic [15:0]      i_code,
  input  wire cw_t              i_cw,
  output logic      [ACC_W-1:0] o_value
);

  logic signed [2:0] w_d_hi;
  logic signed [2:0] w_d_lo;

  // 4-bit codes are two stacked 2-bit levels: hi weighs 4, lo weighs 1
  assign w_d_hi = dec2(i_code[3:2]);
  assign w_d_lo = dec2(i_code[1:0]);

  // Select the expansion for the active code width
  always_comb begin
    o_value = '0;
    case (i_cw)
      CW_2:    o_value = {{(ACC_W-3){w_d_lo[2]}}, w_d_lo};
      CW_4:    o_value = {{(ACC_W-5){w_d_hi[2]}}, w_d_hi, 2'b00}
                       + {{(ACC_W-3){w_d_lo[2]}}, w_d_lo};
      CW_8:    o_value = {{(ACC_W-8){i_code[7]}}, i_code[7:0]};
      default: o_value = {{(ACC_W-16){i_code[15]}}, i_code};
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/act_dequant_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// act_dequant_unit
// Activation dequantizer: buffers one beat of packed 2/4/8/16-bit codes and
// serializes it as signed int lanes over several output beats, with a
// zero-bubble reload of the next input beat on the last sub-beat.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module act_dequant_unit
  import mnisc_pkg::*;
#(
  parameter int BUS_W = 128,
  parameter int ACC_W = 32
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic [7:0]  i_cfg_code_bits,
  input  wire logic [15:0] i_cfg_h,
  input  wire logic [15:0] i_cfg_w,
  input  wire logic [15:0] i_cfg_c,
  input  wire logic        i_start,
  output logic             o_busy,
  output logic             o_done,
  act_dequant_unit_if.slave  i_in,
  act_dequant_unit_if.master o_out
);

  localparam int c_OPB = BUS_W / ACC_W;

  state_t           r_state;
  state_t           w_state_nxt;
  cw_t              r_cw;
  logic [31:0]      r_total;
  logic [31:0]      r_elem_cnt;
  logic [BUS_W-1:0] r_buf;
  logic [3:0]       r_sub;

  logic [31:0]      w_total;
  logic             w_last;
  logic             w_sub_last;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_out_hs;
  logic             w_start_acc;
  logic             w_buf_load;
  logic [BUS_W-1:0] w_lanes;

  // Element count of the requested tensor, wrapped to 32 bits
  assign w_total = 32'(i_cfg_h) * 32'(i_cfg_w) * 32'(i_cfg_c);

  // This output beat covers the final element of the tensor
  assign w_last = ({1'b0, r_elem_cnt} + 33'(c_OPB)) >= {1'b0, r_total};

  assign w_sub_last = (r_sub == sub_last(r_cw));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, handshake and datapath-strobe decode
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_out_hs    = 1'b0;
    w_start_acc = 1'b0;
    w_buf_load  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_start_acc = 1'b1;
          w_state_nxt = (w_total == 32'd0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_in_ready = 1'b1;
        if (i_in.valid) begin
          w_buf_load  = 1'b1;
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_out_valid = 1'b1;
        // Accept the next beat only as the last sub-beat leaves, and only if
        // more elements remain; out_ready feeds in_ready combinationally.
        w_in_ready  = o_out.ready && w_sub_last && !w_last;
        if (o_out.ready) begin
          w_out_hs = 1'b1;
          if (w_last) begin
            w_state_nxt = ST_DONE;
          end else if (w_sub_last) begin
            if (i_in.valid) begin
              w_buf_load = 1'b1;
            end else begin
              w_state_nxt = ST_LOAD;
            end
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Config latch, element/sub-beat counters and input buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cw       <= CW_2;
      r_total    <= '0;
      r_elem_cnt <= '0;
      r_buf      <= '0;
      r_sub      <= '0;
    end else begin
      if (w_start_acc) begin
        r_cw       <= cw_decode(i_cfg_code_bits);
        r_total    <= w_total;
        r_elem_cnt <= '0;
        r_sub      <= '0;
      end
      if (w_out_hs) begin
        r_elem_cnt <= r_elem_cnt + 32'(c_OPB);
        r_sub      <= r_sub + 4'd1;
      end
      // A reload restarts the sub-beat walk even when it coincides with a drain
      if (w_buf_load) begin
        r_buf <= i_in.data;
        r_sub <= '0;
      end
    end
  end

  generate
    for (genvar j = 0; j < c_OPB; j++) begin : g_lane
      logic [31:0]      w_idx;
      logic [15:0]      w_code;
      logic [ACC_W-1:0] w_value;
      logic             w_en;

      // Code index within the buffer for this lane of the current sub-beat
      assign w_idx = 32'(r_sub) * 32'(c_OPB) + 32'(j);

      // Extract this lane's code, right-aligned
      always_comb begin
        w_code = '0;
        case (r_cw)
          CW_2:    w_code = {14'd0, 2'(r_buf >> (w_idx * 32'd2))};
          CW_4:    w_code = {12'd0, 4'(r_buf >> (w_idx * 32'd4))};
          CW_8:    w_code = {8'd0, 8'(r_buf >> (w_idx * 32'd8))};
          default: w_code = 16'(r_buf >> (w_idx * 32'd16));
        endcase
      end

      mnisc_code_decoder #(
        .ACC_W (ACC_W)
      ) u_dec (
        .i_code  (w_code),
        .i_cw    (r_cw),
        .o_value (w_value)
      );

      // Lanes past the end of the tensor read as zero
      assign w_en = (r_state == ST_DRAIN)
                 && (({1'b0, r_elem_cnt} + 33'(j)) < {1'b0, r_total});

      assign w_lanes[j*ACC_W +: ACC_W] = w_en ? w_value : '0;
    end
  endgenerate

  assign i_in.ready  = w_in_ready;
  assign o_out.valid = w_out_valid;
  assign o_out.data  = w_lanes;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_done      = (r_state == ST_DONE);

endmodule
`default_nettype wire
